// File: rtl/seq_arb_nin_weighted.sv
// Weighted round-robin arbiter: requester i gets weight[i]+1 back-to-back grants
// per round, with credits refilled when no requester has credit left.
module seq_arb_nin_weighted #(
  parameter int NREQS = 8,
  parameter int WBITS = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             preset,
  input  logic             weight_we,
  input  logic [3:0]       weight_idx,
  input  logic [WBITS-1:0] weight_data,
  input  logic [NREQS-1:0] reqs,
  output logic [NREQS-1:0] grants
);

  localparam int          PW   = $clog2(NREQS);
  localparam int          CW   = WBITS + 1;
  localparam int unsigned N    = NREQS;
  localparam logic [PW-1:0] LAST = PW'(NREQS - 1);

  logic [WBITS-1:0] r_weight [NREQS];
  logic [CW-1:0]    r_credit [NREQS];
  logic [PW-1:0]    r_ptr;

  logic [NREQS-1:0] w_elig;
  logic [NREQS-1:0] w_scan;
  logic [CW-1:0]    w_reload [NREQS];
  logic             w_any_req;
  logic             w_any_elig;
  logic [PW-1:0]    w_gidx;
  logic [CW-1:0]    w_gcredit_nxt;
  logic [PW-1:0]    w_ptr_nxt;

  always_comb begin
    w_elig = '0;
    for (int unsigned j = 0; j < N; j++) begin
      w_elig[j]   = reqs[j] & (r_credit[j] != '0);
      w_reload[j] = CW'(r_weight[j]) + CW'(1);
    end
    w_any_req  = |reqs;
    w_any_elig = |w_elig;
  end

  // A refill cycle arbitrates among all requesters, otherwise only among those with credit.
  always_comb begin
    logic        found;
    int unsigned idx;
    found  = 1'b0;
    idx    = 0;
    w_gidx = '0;
    w_scan = w_any_elig ? w_elig : reqs;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(r_ptr) + k) % N;
      if (!found && w_scan[PW'(idx)]) begin
        found  = 1'b1;
        w_gidx = PW'(idx);
      end
    end
  end

  always_comb begin
    grants = '0;
    if (reset_n && !preset && w_any_req) begin
      grants[w_gidx] = 1'b1;
    end
    w_gcredit_nxt = w_any_elig ? (r_credit[w_gidx] - CW'(1)) : CW'(r_weight[w_gidx]);
    if (w_gcredit_nxt != '0) begin
      w_ptr_nxt = w_gidx;
    end else if (w_gidx == LAST) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = w_gidx + PW'(1);
    end
  end

  // Reloads read r_weight before the write lands, so a same-cycle write only affects later rounds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned j = 0; j < N; j++) begin
        r_weight[j] <= '0;
        r_credit[j] <= CW'(1);
      end
      r_ptr <= '0;
    end else begin
      for (int unsigned j = 0; j < N; j++) begin
        if (weight_we && (weight_idx == 4'(j))) begin
          r_weight[j] <= weight_data;
        end
      end
      if (preset) begin
        for (int unsigned j = 0; j < N; j++) begin
          r_credit[j] <= w_reload[j];
        end
        r_ptr <= '0;
      end else if (w_any_req) begin
        if (!w_any_elig) begin
          for (int unsigned j = 0; j < N; j++) begin
            r_credit[j] <= (PW'(j) == w_gidx) ? w_gcredit_nxt : w_reload[j];
          end
        end else begin
          r_credit[w_gidx] <= w_gcredit_nxt;
        end
        r_ptr <= w_ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seq_arb_nin_weighted.sv
// Bench for seq_arb_nin_weighted (NREQS=4, WBITS=2): directed sequences with literal
// expectations plus a per-cycle comparison against a credit/pointer model.
module tb_seq_arb_nin_weighted;

  logic       clk;
  logic       reset_n;
  logic       preset;
  logic       weight_we;
  logic [3:0] weight_idx;
  logic [1:0] weight_data;
  logic [3:0] reqs;
  logic [3:0] grants;

  int checks = 0;
  int errors = 0;

  int m_w [4] = '{0, 0, 0, 0};
  int m_c [4] = '{1, 1, 1, 1};
  int m_p     = 0;

  logic [3:0] exp_q [$];

  seq_arb_nin_weighted #(.NREQS(4), .WBITS(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .preset     (preset),
    .weight_we  (weight_we),
    .weight_idx (weight_idx),
    .weight_data(weight_data),
    .reqs       (reqs),
    .grants     (grants)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: grants=%b expected=%b at %0t", name, act, expv, $time);
    end
  endtask

  // Winner under the arbitration rules; refill=1 when no requester holds credit.
  function automatic int pick(input logic [3:0] r, output bit refill);
    bit any_e;
    int idx;
    any_e = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (r[j] && m_c[j] != 0) any_e = 1'b1;
    end
    refill = !any_e;
    for (int k = 0; k < 4; k++) begin
      idx = (m_p + k) % 4;
      if (r[idx] && (refill || m_c[idx] != 0)) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    int g;
    bit rf;
    if (!reset_n) begin
      for (int j = 0; j < 4; j++) begin
        m_w[j] = 0;
        m_c[j] = 1;
      end
      m_p = 0;
    end else begin
      if (preset) begin
        for (int j = 0; j < 4; j++) m_c[j] = m_w[j] + 1;
        m_p = 0;
      end else if (reqs != 4'b0000) begin
        g = pick(reqs, rf);
        if (rf) begin
          for (int j = 0; j < 4; j++) m_c[j] = m_w[j] + 1;
          m_c[g] = m_w[g];
        end else begin
          m_c[g] = m_c[g] - 1;
        end
        m_p = (m_c[g] != 0) ? g : (g + 1) % 4;
      end
      if (weight_we && weight_idx < 4) m_w[weight_idx] = int'(weight_data);
    end
  end

  always @(negedge clk) begin
    logic [3:0] expv;
    int g;
    bit rf;
    expv = 4'b0000;
    if (reset_n && !preset && reqs != 4'b0000) begin
      g = pick(reqs, rf);
      expv[g] = 1'b1;
    end
    check("model", grants, expv);
    checks++;
    if ($countones(grants) > 1 || (grants & ~reqs) != 4'b0000) begin
      errors++;
      $display("FAIL onehot_subset: grants=%b reqs=%b at %0t", grants, reqs, $time);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    preset    = 1'b0;
    weight_we = 1'b0;
    reqs      = 4'hF;
    #1 check("reset_grants", grants, 4'b0000);
    cyc();
    reqs    = 4'h0;
    reset_n = 1'b1;
  endtask

  task automatic write_w(input logic [3:0] idx, input logic [1:0] data);
    weight_we   = 1'b1;
    weight_idx  = idx;
    weight_data = data;
    cyc();
    weight_we = 1'b0;
  endtask

  task automatic pulse_preset();
    preset = 1'b1;
    reqs   = 4'hF;
    @(negedge clk);
    check("preset_grants", grants, 4'b0000);
    cyc();
    preset = 1'b0;
    reqs   = 4'h0;
  endtask

  task automatic run(input logic [3:0] r, input string name);
    reqs = r;
    foreach (exp_q[i]) begin
      @(negedge clk);
      check(name, grants, exp_q[i]);
      cyc();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: grants=%b expected=summary at %0t", grants, $time);
    $fatal(1);
  end

  initial begin
    preset = 1'b0; weight_we = 1'b0; weight_idx = 4'd0; weight_data = 2'd0; reqs = 4'h0;
    do_reset();

    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    run(4'b1111, "rr_plain");

    do_reset();
    write_w(4'd0, 2'd1);
    pulse_preset();
    exp_q = '{4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0010,
              4'b0001, 4'b0001, 4'b0010};
    run(4'b0011, "w0_burst");

    do_reset();
    write_w(4'd2, 2'd3);
    pulse_preset();
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000,
              4'b0001, 4'b0010, 4'b0100};
    run(4'b1111, "w2_burst");

    do_reset();
    write_w(4'd2, 2'd3);
    pulse_preset();
    exp_q = '{4'b0001, 4'b0010};
    run(4'b1111, "preset_mid_a");
    preset = 1'b1;
    @(negedge clk);
    check("preset_mid_zero", grants, 4'b0000);
    cyc();
    preset = 1'b0;
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000};
    run(4'b1111, "preset_mid_b");

    exp_q = '{4'b0001, 4'b0010, 4'b0100};
    run(4'b1111, "pre_async_rst");
    #2 reset_n = 1'b0;
    #1 check("async_rst_zero", grants, 4'b0000);
    cyc();
    reset_n = 1'b1;
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    run(4'b1111, "after_async_rst");

    do_reset();
    write_w(4'd7, 2'd3);
    pulse_preset();
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    run(4'b1111, "idx_out_of_range");

    // Write landing together with preset: credits come from the old weight.
    do_reset();
    weight_we = 1'b1; weight_idx = 4'd1; weight_data = 2'd2; preset = 1'b1;
    cyc();
    weight_we = 1'b0; preset = 1'b0;
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0010,
              4'b0010, 4'b0100};
    run(4'b1111, "write_with_preset");

    exp_q = '{4'b0000, 4'b0000};
    run(4'b0000, "idle_hold");
    exp_q = '{4'b1000, 4'b0001};
    run(4'b1111, "resume_after_idle");

    do_reset();
    for (int n = 0; n < 400; n++) begin
      reqs        = 4'($urandom_range(0, 15));
      preset      = ($urandom_range(0, 15) == 0);
      weight_we   = ($urandom_range(0, 7) == 0);
      weight_idx  = 4'($urandom_range(0, 7));
      weight_data = 2'($urandom_range(0, 3));
      cyc();
    end
    reqs = 4'h0; preset = 1'b0; weight_we = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
